// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock, 32-cycle latency.
// Holds the execute stage via stall until {HI,LO} = {remainder, quotient} is ready.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic               annul,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dsr;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_op1_abs;
    logic [WIDTH-1:0]   w_op2_abs;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;

    assign w_accept  = start && !annul;
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_op1_abs = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
    assign w_op2_abs = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;

    // Borrow out of the (WIDTH+1)-bit subtract tells us whether the divisor fits.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_dsr};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    // Remainder follows the dividend sign; quotient is negative when signs differ.
    assign w_quo_fix = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    assign w_rem_fix = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (opdata2 == '0) ? S_DIVZERO : S_ON;
                end
            end
            S_DIVZERO: begin
                w_state_nxt = annul ? S_IDLE : S_END;
            end
            S_ON: begin
                if (annul) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_END;
                end
            end
            S_END: begin
                // Wait for the request to drop so a held start cannot retrigger.
                if (!start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dsr    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == S_END);
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (opdata2 != '0)) begin
                        r_cnt   <= '0;
                        r_quo   <= w_op1_abs;
                        r_rem   <= '0;
                        r_dsr   <= w_op2_abs;
                        r_neg_q <= signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        r_neg_r <= signed_div && opdata1[WIDTH-1];
                    end
                end
                S_DIVZERO: begin
                    if (!annul) begin
                        r_result <= '0;
                    end
                end
                S_ON: begin
                    if (!annul) begin
                        r_cnt <= r_cnt + 1'b1;
                        r_quo <= w_quo_nxt;
                        r_rem <= w_rem_nxt;
                        if (w_last) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign ready  = r_ready;
    assign stall  = start && !r_ready;

endmodule
